// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arb
// Purpose  : Packet-locked round-robin arbiter sharing one FIFO write port.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH_DATA = 8,
    parameter int MAX_BEATS  = 0,
    parameter int _WIDTH_ID  = $clog2(NUM_REQ),
    parameter int _WIDTH_BC  = $clog2(MAX_BEATS + 2)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*WIDTH_DATA-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [WIDTH_DATA-1:0]         fifo_wr_data,
    output logic [_WIDTH_ID-1:0]          grant_id,
    output logic                          busy,
    output logic                          ovl_pulse
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    localparam logic [_WIDTH_ID-1:0] c_last_init = _WIDTH_ID'(NUM_REQ - 1);
    localparam logic [_WIDTH_BC-1:0] c_max_beats = _WIDTH_BC'(MAX_BEATS);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [_WIDTH_ID-1:0]  r_grant_id;
    logic [_WIDTH_ID-1:0]  r_last_winner;
    logic [_WIDTH_BC-1:0]  r_beat_cnt;
    logic                  r_ovl_pulse;

    logic [_WIDTH_ID-1:0]  w_winner;
    logic [_WIDTH_ID-1:0]  w_idx;
    logic [_WIDTH_BC-1:0]  w_cnt_inc;
    logic                  w_xfer;
    logic                  w_force_rel;
    logic [WIDTH_DATA-1:0] w_req_data [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_req_data[g] = req_data[g*WIDTH_DATA +: WIDTH_DATA];
    end

    assign w_cnt_inc = r_beat_cnt + 1'b1;

    // Walk candidates farthest-first so the one nearest last_winner+1 wins.
    always_comb begin
        w_winner = r_last_winner;
        w_idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = _WIDTH_ID'((int'(r_last_winner) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_xfer       = 1'b0;
        w_force_rel  = 1'b0;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    w_state_nxt = S_LOCK;
                end
            end
            S_LOCK: begin
                req_ready[r_grant_id] = !fifo_full;
                if (req_valid[r_grant_id] && !fifo_full) begin
                    w_xfer       = 1'b1;
                    fifo_wr_en   = 1'b1;
                    fifo_wr_data = w_req_data[r_grant_id];
                    // A natural last beat takes precedence over the beat limit.
                    if (req_last[r_grant_id]) begin
                        w_state_nxt = S_IDLE;
                    end else if ((MAX_BEATS != 0) && (w_cnt_inc == c_max_beats)) begin
                        w_state_nxt = S_IDLE;
                        w_force_rel = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_id    <= '0;
            r_last_winner <= c_last_init;
            r_beat_cnt    <= '0;
            r_ovl_pulse   <= 1'b0;
        end else begin
            r_ovl_pulse <= w_force_rel;
            if ((r_state == S_IDLE) && (|req_valid)) begin
                r_grant_id    <= w_winner;
                r_last_winner <= w_winner;
                r_beat_cnt    <= '0;
            end else if (w_xfer) begin
                r_beat_cnt <= w_cnt_inc;
            end
        end
    end

    assign grant_id  = r_grant_id;
    assign ovl_pulse = r_ovl_pulse;
    assign busy      = (r_state == S_LOCK);

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arb
// Purpose  : Self-checking bench for fifo_wr_arb against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arb;

    localparam int NUM_REQ    = 4;
    localparam int WIDTH_DATA = 8;
    localparam int MAX_BEATS  = 4;
    localparam int DEPTH      = 128;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*WIDTH_DATA-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [WIDTH_DATA-1:0]         fifo_wr_data;
    logic [1:0]                    grant_id;
    logic                          busy;
    logic                          ovl_pulse;

    fifo_wr_arb #(
        .NUM_REQ    (NUM_REQ),
        .WIDTH_DATA (WIDTH_DATA),
        .MAX_BEATS  (MAX_BEATS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .busy         (busy),
        .ovl_pulse    (ovl_pulse)
    );

    always #5 clk = ~clk;

    // Per-requester packet sources
    logic [7:0] src_data [NUM_REQ][DEPTH];
    bit         src_last [NUM_REQ][DEPTH];
    int         head [NUM_REQ];
    int         tail [NUM_REQ];
    bit         hold [NUM_REQ];
    bit         rst_v;
    bit         full_v;

    // Behavioural arbiter model
    bit m_locked;
    bit m_ovl;
    int m_gid;
    int m_lastw;
    int m_cnt;

    logic [16:0] exp_vec;
    wire  [16:0] dut_vec = {busy, grant_id, req_ready, fifo_wr_en, fifo_wr_data, ovl_pulse};

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    task automatic clear_sources();
        for (int i = 0; i < NUM_REQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
            hold[i] = 1'b0;
        end
    endtask

    task automatic push_pkt(input int r, input int len);
        for (int b = 0; b < len; b++) begin
            if (tail[r] < DEPTH) begin
                src_data[r][tail[r]] = 8'($urandom);
                src_last[r][tail[r]] = (b == len - 1);
                tail[r]++;
            end
        end
    endtask

    task automatic drive();
        logic [3:0] rdy;
        bit         has;
        bit         x;
        rst       = rst_v;
        fifo_full = full_v;
        for (int i = 0; i < NUM_REQ; i++) begin
            has = head[i] < tail[i];
            req_valid[i] = has && !hold[i];
            req_last[i]  = has ? src_last[i][head[i]] : 1'b0;
            req_data[i*WIDTH_DATA +: WIDTH_DATA] = has ? src_data[i][head[i]] : 8'h00;
        end
        x   = m_locked && req_valid[m_gid] && !fifo_full;
        rdy = (m_locked && !fifo_full) ? 4'(1 << m_gid) : 4'b0000;
        exp_vec = {m_locked, 2'(m_gid), rdy, x,
                   x ? req_data[m_gid*WIDTH_DATA +: WIDTH_DATA] : 8'h00, m_ovl};
    endtask

    // Advance one clock: apply the arbitration rules to the inputs seen at the
    // edge, retire accepted beats, then present the next inputs.
    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_locked = 1'b0;
            m_gid    = 0;
            m_lastw  = NUM_REQ - 1;
            m_cnt    = 0;
            m_ovl    = 1'b0;
        end else if (!m_locked) begin
            m_ovl = 1'b0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                int cand;
                cand = (m_lastw + k) % NUM_REQ;
                if (!m_locked && req_valid[cand]) begin
                    m_locked = 1'b1;
                    m_gid    = cand;
                    m_lastw  = cand;
                    m_cnt    = 0;
                end
            end
        end else begin
            m_ovl = 1'b0;
            if (req_valid[m_gid] && !fifo_full) begin
                m_cnt++;
                head[m_gid]++;
                if (req_last[m_gid]) begin
                    m_locked = 1'b0;
                end else if (m_cnt == MAX_BEATS) begin
                    m_locked = 1'b0;
                    m_ovl    = 1'b1;
                end
            end
        end
        #1;
        drive();
        #1;
    endtask

    task automatic do_reset();
        rst_v = 1'b1;
        step();
        clear_sources();
        full_v = 1'b0;
        rst_v  = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_v  = 1'b1;
        full_v = 1'b0;
        clear_sources();
        for (int i = 0; i < NUM_REQ; i++) push_pkt(i, 2);
        m_locked = 1'b0; m_gid = 0; m_lastw = NUM_REQ - 1; m_cnt = 0; m_ovl = 1'b0;
        drive();
        step();
        checks++;
        if (dut_vec !== 17'h0) begin
            fails++;
            $display("FAIL reset_vals_1 got=%h exp=%h", dut_vec, 17'h0);
        end
        rst_v = 1'b0;
        step();
        checks++;
        if (dut_vec !== 17'h0) begin
            fails++;
            $display("FAIL reset_vals_2 got=%h exp=%h", dut_vec, 17'h0);
        end
        step();
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL reset_first_grant busy=%b gid=%0d rdy=%b exp busy=1 gid=0 rdy=0001",
                     busy, grant_id, req_ready);
        end
        checks++;
        if (dut_vec !== exp_vec) begin
            fails++;
            $display("FAIL reset_model t=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
        end
    endtask

    task automatic test_round_robin();
        int  obs[$];
        int  first_cyc;
        int  fifth_cyc;
        int  beats;
        bit  prev_busy;
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < NUM_REQ; i++) push_pkt(i, 2);
        prev_busy = 1'b0;
        beats = 0; first_cyc = 0; fifth_cyc = 0;
        for (int n = 0; n < 60 && obs.size() < 5; n++) begin
            step();
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++;
                $display("FAIL rr_cycle t=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            end
            if (busy && !prev_busy) begin
                obs.push_back(int'(grant_id));
                if (obs.size() == 1) first_cyc = cyc;
                if (obs.size() == 5) fifth_cyc = cyc;
            end
            if (obs.size() >= 1 && obs.size() < 5 && fifo_wr_en) beats++;
            prev_busy = busy;
        end
        checks++;
        if (obs.size() != 5) begin
            fails++;
            $display("FAIL rr_grants got=%0d grants exp=5", obs.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs[i] != i % NUM_REQ) begin
                    fails++;
                    $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, obs[i], i % NUM_REQ);
                end
            end
            checks++;
            if (beats != 8 || fifth_cyc - first_cyc != 12) begin
                fails++;
                $display("FAIL rr_round beats=%0d cycles=%0d exp beats=8 cycles=12",
                         beats, fifth_cyc - first_cyc);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] obs[$];
        bit         seen_ovl;
        do_reset();
        push_pkt(2, 4);
        seen_ovl = 1'b0;
        for (int n = 0; n < 10 && obs.size() == 0; n++) begin
            step();
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++;
                $display("FAIL bp_cycle t=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            end
            if (fifo_wr_en) obs.push_back(fifo_wr_data);
        end
        full_v = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (req_ready !== 4'b0 || fifo_wr_en !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd2) begin
                fails++;
                $display("FAIL bp_hold t=%0d rdy=%b wr_en=%b busy=%b gid=%0d exp rdy=0000 wr_en=0 busy=1 gid=2",
                         cyc, req_ready, fifo_wr_en, busy, grant_id);
            end
        end
        full_v = 1'b0;
        for (int n = 0; n < 8; n++) begin
            step();
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++;
                $display("FAIL bp_cycle t=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            end
            if (fifo_wr_en) obs.push_back(fifo_wr_data);
            if (ovl_pulse) seen_ovl = 1'b1;
        end
        checks++;
        if (obs.size() != 4) begin
            fails++;
            $display("FAIL bp_count got=%0d beats exp=4", obs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs[i] !== src_data[2][i]) begin
                    fails++;
                    $display("FAIL bp_data idx=%0d got=%h exp=%h", i, obs[i], src_data[2][i]);
                end
            end
        end
        checks++;
        if (seen_ovl) begin
            fails++;
            $display("FAIL bp_last_at_limit ovl_pulse got=1 exp=0");
        end
    endtask

    task automatic test_overlength();
        int         grants[$];
        logic [7:0] beats1[$];
        int         beat4_cyc;
        int         ovl_cyc;
        int         ovl_cnt;
        bit         prev_busy;
        do_reset();
        push_pkt(1, 6);
        for (int n = 0; n < 10 && !busy; n++) step();
        for (int i = 0; i < NUM_REQ; i++)
            if (i != 1) push_pkt(i, 2);
        prev_busy = 1'b1;
        beat4_cyc = -1; ovl_cyc = -1; ovl_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++;
                $display("FAIL ovl_cycle t=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            end
            if (fifo_wr_en && grant_id == 2'd1) begin
                beats1.push_back(fifo_wr_data);
                if (beats1.size() == 4) beat4_cyc = cyc;
            end
            if (ovl_pulse) begin
                ovl_cnt++;
                ovl_cyc = cyc;
            end
            if (busy && !prev_busy) grants.push_back(int'(grant_id));
            prev_busy = busy;
            step();
        end
        checks++;
        if (ovl_cnt != 1 || ovl_cyc != beat4_cyc + 1) begin
            fails++;
            $display("FAIL ovl_pulse count=%0d at=%0d exp count=1 at=%0d", ovl_cnt, ovl_cyc, beat4_cyc + 1);
        end
        checks++;
        if (grants.size() != 4) begin
            fails++;
            $display("FAIL ovl_regrant got=%0d grants exp=4", grants.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grants[i] != (i + 2) % NUM_REQ) begin
                    fails++;
                    $display("FAIL ovl_order idx=%0d got=%0d exp=%0d", i, grants[i], (i + 2) % NUM_REQ);
                end
            end
        end
        checks++;
        if (beats1.size() != 6) begin
            fails++;
            $display("FAIL ovl_beats got=%0d exp=6", beats1.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (beats1[i] !== src_data[1][i]) begin
                    fails++;
                    $display("FAIL ovl_data idx=%0d got=%h exp=%h", i, beats1[i], src_data[1][i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        int beats;
        do_reset();
        push_pkt(3, 5);
        beats = 0;
        for (int n = 0; n < 10 && beats < 2; n++) begin
            step();
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++;
                $display("FAIL rmp_cycle t=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            end
            if (fifo_wr_en) beats++;
        end
        push_pkt(1, 2);
        push_pkt(2, 2);
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || ovl_pulse !== 1'b0) begin
            fails++;
            $display("FAIL rmp_reset busy=%b gid=%0d ovl=%b exp busy=0 gid=0 ovl=0", busy, grant_id, ovl_pulse);
        end
        step();
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd1) begin
            fails++;
            $display("FAIL rmp_regrant busy=%b gid=%0d exp busy=1 gid=1", busy, grant_id);
        end
        checks++;
        if (dut_vec !== exp_vec) begin
            fails++;
            $display("FAIL rmp_model t=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
        end
    endtask

    task automatic test_valid_gap();
        int         ids[$];
        logic [7:0] dat[$];
        do_reset();
        push_pkt(0, 3);
        push_pkt(2, 2);
        for (int n = 0; n < 10 && ids.size() == 0; n++) begin
            step();
            if (fifo_wr_en) begin
                ids.push_back(int'(grant_id));
                dat.push_back(fifo_wr_data);
            end
        end
        hold[0] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if (busy !== 1'b1 || grant_id !== 2'd0 || fifo_wr_en !== 1'b0) begin
                fails++;
                $display("FAIL gap_hold t=%0d busy=%b gid=%0d wr_en=%b exp busy=1 gid=0 wr_en=0",
                         cyc, busy, grant_id, fifo_wr_en);
            end
        end
        hold[0] = 1'b0;
        for (int n = 0; n < 12; n++) begin
            step();
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++;
                $display("FAIL gap_cycle t=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            end
            if (fifo_wr_en) begin
                ids.push_back(int'(grant_id));
                dat.push_back(fifo_wr_data);
            end
        end
        checks++;
        if (ids.size() != 5) begin
            fails++;
            $display("FAIL gap_beats got=%0d exp=5", ids.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                int         r;
                logic [7:0] d;
                r = (i < 3) ? 0 : 2;
                d = (i < 3) ? src_data[0][i] : src_data[2][i-3];
                checks++;
                if (ids[i] != r || dat[i] !== d) begin
                    fails++;
                    $display("FAIL gap_order idx=%0d got id=%0d data=%h exp id=%0d data=%h",
                             i, ids[i], dat[i], r, d);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                int r;
                r = int'($urandom_range(0, NUM_REQ - 1));
                if (tail[r] < DEPTH - 8) push_pkt(r, int'($urandom_range(1, 6)));
            end
            full_v = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NUM_REQ; i++) hold[i] = ($urandom_range(0, 9) == 0);
            step();
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++;
                $display("FAIL rand_cycle t=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            end
        end
        full_v = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) hold[i] = 1'b0;
        for (int n = 0; n < 600; n++) begin
            step();
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++;
                $display("FAIL rand_drain t=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            end
            if (!m_locked && head[0] == tail[0] && head[1] == tail[1] &&
                head[2] == tail[2] && head[3] == tail[3]) break;
        end
        step();
        checks++;
        if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
            fails++;
            $display("FAIL rand_idle busy=%b wr_en=%b exp busy=0 wr_en=0", busy, fifo_wr_en);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_back_pressure();
        test_overlength();
        test_reset_mid_packet();
        test_valid_gap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
